// File: rtl/jpeg_block_pingpong_ctrl.sv
// jpeg_block_pingpong_ctrl
//
// Ping-pong controller for two DEPTH-entry pixel block buffers in the JPEG
// encoder front end. A raster pixel stream is written into one bank while
// the other bank is read by the DCT stage. The upstream stream stalls only
// when both banks hold blocks that the consumer has not yet freed.
//
// Parameters
//   DATA_WIDTH  pixel/sample width
//   DEPTH       samples per block (power of two)
//   CNT_WIDTH   width of the completed-block counter
//
// Ports
//   clock        single clock, all state changes on its rising edge
//   reset_n      asynchronous active-low reset
//   pix_valid    upstream pixel valid
//   pix_data     upstream pixel value
//   pix_ready    controller can accept a pixel this cycle
//   bank0_wr_en  1-pixel write enable of bank 0
//   bank1_wr_en  1-pixel write enable of bank 1
//   wr_data      write data shared by both banks (equals pix_data)
//   blk_valid    a complete block is available in bank blk_bank
//   blk_bank     bank index the consumer must read
//   blk_ready    consumer is done with bank blk_bank, frees it
//   occupancy    number of banks currently FULL (0..2)
//   blk_cnt      blocks released to the consumer since reset, wraps

module jpeg_block_pingpong_ctrl #(
    parameter int DATA_WIDTH = 10,
    parameter int DEPTH      = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  pix_valid,
    input  logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_ready,
    output logic                  bank0_wr_en,
    output logic                  bank1_wr_en,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  blk_valid,
    output logic                  blk_bank,
    input  logic                  blk_ready,
    output logic [1:0]            occupancy,
    output logic [CNT_WIDTH-1:0]  blk_cnt
);

    localparam int               PIX_W    = $clog2(DEPTH);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(DEPTH - 1);

    // A bank is either being filled (or empty) or holds a complete block
    // waiting for the consumer.
    typedef enum logic {
        BANK_FILLING = 1'b0,
        BANK_FULL    = 1'b1
    } bank_state_e;

    bank_state_e            bank0_q, bank0_d;
    bank_state_e            bank1_q, bank1_d;
    logic                   wr_bank_q, wr_bank_d;
    logic                   rd_bank_q, rd_bank_d;
    logic [PIX_W-1:0]       pix_cnt_q, pix_cnt_d;
    logic [CNT_WIDTH-1:0]   blk_cnt_q, blk_cnt_d;

    logic                   wr_bank_full;
    logic                   rd_bank_full;
    logic                   accept;
    logic                   fill_done;
    logic                   rel_evt;

    // Handshake decode. Ready depends only on registered state, so a bank
    // that is freed this cycle cannot also be written this cycle.
    always_comb begin
        wr_bank_full = wr_bank_q ? (bank1_q == BANK_FULL) : (bank0_q == BANK_FULL);
        rd_bank_full = rd_bank_q ? (bank1_q == BANK_FULL) : (bank0_q == BANK_FULL);
        pix_ready    = !wr_bank_full;
        accept       = pix_valid & pix_ready;
        fill_done    = accept & (pix_cnt_q == LAST_PIX);
        rel_evt      = rd_bank_full & blk_ready;
    end

    // Next-state logic. A fill completion and a release in the same cycle
    // always hit different banks (the write bank of a pending release is
    // FULL and therefore not accepting), so both updates can be applied
    // independently.
    always_comb begin
        bank0_d   = bank0_q;
        bank1_d   = bank1_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        pix_cnt_d = pix_cnt_q;
        blk_cnt_d = blk_cnt_q;

        if (accept) begin
            pix_cnt_d = pix_cnt_q + 1'b1;
        end

        if (fill_done) begin
            pix_cnt_d = '0;
            wr_bank_d = ~wr_bank_q;
            if (wr_bank_q) begin
                bank1_d = BANK_FULL;
            end else begin
                bank0_d = BANK_FULL;
            end
        end

        if (rel_evt) begin
            rd_bank_d = ~rd_bank_q;
            blk_cnt_d = blk_cnt_q + 1'b1;
            if (rd_bank_q) begin
                bank1_d = BANK_FILLING;
            end else begin
                bank0_d = BANK_FILLING;
            end
        end
    end

    // State registers. Reset drops any partial block and any FULL banks so
    // the next pixel lands in bank 0 at index 0, matching the banks' own
    // write indices which share this reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bank0_q   <= BANK_FILLING;
            bank1_q   <= BANK_FILLING;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            pix_cnt_q <= '0;
            blk_cnt_q <= '0;
        end else begin
            bank0_q   <= bank0_d;
            bank1_q   <= bank1_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            pix_cnt_q <= pix_cnt_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

    // Bank write steering and consumer-side outputs.
    always_comb begin
        bank0_wr_en = accept & (wr_bank_q == 1'b0);
        bank1_wr_en = accept & (wr_bank_q == 1'b1);
        wr_data     = pix_data;
        blk_valid   = rd_bank_full;
        blk_bank    = rd_bank_q;
        occupancy   = {1'b0, bank0_q == BANK_FULL} + {1'b0, bank1_q == BANK_FULL};
        blk_cnt     = blk_cnt_q;
    end

endmodule

// File: tb/tb_jpeg_block_pingpong_ctrl.sv
// tb_jpeg_block_pingpong_ctrl
//
// Directed bench for jpeg_block_pingpong_ctrl. A behavioural model of the two
// pixel banks captures writes so block contents can be compared against the
// pixels that were sent. A second, small instance (DEPTH=4, CNT_WIDTH=4)
// exercises the block counter wrap in a short run.

module tb_jpeg_block_pingpong_ctrl;

    localparam int DW    = 10;
    localparam int DEPTH = 64;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          pix_valid;
    logic [DW-1:0] pix_data;
    logic          pix_ready;
    logic          bank0_wr_en;
    logic          bank1_wr_en;
    logic [DW-1:0] wr_data;
    logic          blk_valid;
    logic          blk_bank;
    logic          blk_ready;
    logic [1:0]    occupancy;
    logic [15:0]   blk_cnt;

    logic          w_pix_valid;
    logic [DW-1:0] w_pix_data;
    logic          w_pix_ready;
    logic          w_bank0_wr_en;
    logic          w_bank1_wr_en;
    logic [DW-1:0] w_wr_data;
    logic          w_blk_valid;
    logic          w_blk_bank;
    logic          w_blk_ready;
    logic [1:0]    w_occupancy;
    logic [3:0]    w_blk_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    jpeg_block_pingpong_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_ready   (pix_ready),
        .bank0_wr_en (bank0_wr_en),
        .bank1_wr_en (bank1_wr_en),
        .wr_data     (wr_data),
        .blk_valid   (blk_valid),
        .blk_bank    (blk_bank),
        .blk_ready   (blk_ready),
        .occupancy   (occupancy),
        .blk_cnt     (blk_cnt)
    );

    jpeg_block_pingpong_ctrl #(.DATA_WIDTH(DW), .DEPTH(4), .CNT_WIDTH(4)) dutWrap (
        .clock       (clock),
        .reset_n     (reset_n),
        .pix_valid   (w_pix_valid),
        .pix_data    (w_pix_data),
        .pix_ready   (w_pix_ready),
        .bank0_wr_en (w_bank0_wr_en),
        .bank1_wr_en (w_bank1_wr_en),
        .wr_data     (w_wr_data),
        .blk_valid   (w_blk_valid),
        .blk_bank    (w_blk_bank),
        .blk_ready   (w_blk_ready),
        .occupancy   (w_occupancy),
        .blk_cnt     (w_blk_cnt)
    );

    // Pixel value sent as the k-th pixel of the gapped run.
    function automatic logic [DW-1:0] pixVal(input int k);
        return DW'((k * 37 + 5) % 1024);
    endfunction

    // Bank model plus release scoreboard. Each bank keeps its own write
    // index, cleared by the shared reset exactly like the real buffers.
    logic [DW-1:0] mem [2][DEPTH];
    logic [5:0]    idx0, idx1;
    int            cnt0, cnt1;
    int            wrViolations = 0;
    bit            gapChk = 1'b0;
    int            sbIdx;
    logic          expBank;
    int            relCnt;
    int            gapDataErr;
    int            gapBankErr;

    always @(posedge clock or negedge reset_n) begin : bankModel
        int e;
        if (!reset_n) begin
            idx0       <= '0;
            idx1       <= '0;
            cnt0       <= 0;
            cnt1       <= 0;
            sbIdx      <= 0;
            expBank    <= 1'b0;
            relCnt     <= 0;
            gapDataErr <= 0;
            gapBankErr <= 0;
        end else begin
            if (bank0_wr_en) begin
                mem[0][idx0] <= wr_data;
                idx0         <= idx0 + 1'b1;
                cnt0         <= cnt0 + 1;
            end
            if (bank1_wr_en) begin
                mem[1][idx1] <= wr_data;
                idx1         <= idx1 + 1'b1;
                cnt1         <= cnt1 + 1;
            end
            if (((bank0_wr_en || bank1_wr_en) && !pix_valid) || (bank0_wr_en && bank1_wr_en)) begin
                wrViolations <= wrViolations + 1;
            end
            if (gapChk && blk_valid && blk_ready) begin
                e = 0;
                for (int j = 0; j < DEPTH; j++) begin
                    if (mem[blk_bank][j] !== pixVal(sbIdx + j)) e++;
                end
                gapDataErr <= gapDataErr + e;
                if (blk_bank !== expBank) gapBankErr <= gapBankErr + 1;
                sbIdx   <= sbIdx + DEPTH;
                expBank <= ~expBank;
                relCnt  <= relCnt + 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        #1;
        tick();
        reset_n = 1'b1;
    endtask

    // Offer one pixel and wait (bounded) until it is accepted.
    task automatic applyStimulus(input logic [DW-1:0] v);
        pix_valid = 1'b1;
        pix_data  = v;
        for (int n = 0; n < 200 && !pix_ready; n++) tick();
        if (!pix_ready) checkOutput("sendReady", 32'(pix_ready), 1);
        else tick();
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int nextIdx;
        logic acc;

        reset_n     = 1'b0;
        pix_valid   = 1'b0;
        pix_data    = '0;
        blk_ready   = 1'b0;
        w_pix_valid = 1'b0;
        w_pix_data  = '0;
        w_blk_ready = 1'b0;

        // Outputs while reset is held.
        #1;
        checkOutput("rstReady", 32'(pix_ready), 1);
        checkOutput("rstValid", 32'(blk_valid), 0);
        checkOutput("rstBank", 32'(blk_bank), 0);
        checkOutput("rstOcc", 32'(occupancy), 0);
        checkOutput("rstCnt", 32'(blk_cnt), 0);
        pix_valid = 1'b1;
        #1;
        checkOutput("rstWr0", 32'(bank0_wr_en), 1);
        checkOutput("rstWr1", 32'(bank1_wr_en), 0);
        pix_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Single block, values 0..63.
        $display("[TB] single block");
        for (int i = 0; i < DEPTH; i++) applyStimulus(DW'(i));
        pix_valid = 1'b0;
        checkOutput("blk1Wr0", 32'(cnt0), 64);
        checkOutput("blk1Wr1", 32'(cnt1), 0);
        checkOutput("blk1Valid", 32'(blk_valid), 1);
        checkOutput("blk1Bank", 32'(blk_bank), 0);
        checkOutput("blk1Occ", 32'(occupancy), 1);
        for (int i = 0; i < DEPTH; i++) checkOutput("blk1Data", 32'(mem[0][i]), 32'(i));

        // Backpressure: 130 offered, 128 accepted.
        $display("[TB] backpressure");
        doReset();
        nextIdx   = 0;
        pix_valid = 1'b1;
        pix_data  = '0;
        for (int c = 0; c < 130; c++) begin
            acc = pix_ready;
            tick();
            if (acc) nextIdx++;
            pix_data = DW'(nextIdx);
        end
        checkOutput("bpAccepted", 32'(cnt0 + cnt1), 128);
        checkOutput("bpReady", 32'(pix_ready), 0);
        checkOutput("bpOcc", 32'(occupancy), 2);
        blk_ready = 1'b1;
        tick();
        blk_ready = 1'b0;
        checkOutput("bpCnt", 32'(blk_cnt), 1);
        checkOutput("bpBank", 32'(blk_bank), 1);
        checkOutput("bpReadyAfter", 32'(pix_ready), 1);
        checkOutput("bpWr0", 32'(bank0_wr_en), 1);
        tick();
        pix_valid = 1'b0;
        checkOutput("bpPix129", 32'(mem[0][0]), 128);
        checkOutput("bpBank1Last", 32'(mem[1][63]), 127);
        checkOutput("bpIdx0", 32'(idx0), 1);

        // Concurrent fill-complete of bank1 and release of bank0.
        $display("[TB] concurrent events");
        doReset();
        for (int i = 0; i < DEPTH; i++) applyStimulus(DW'(i));
        for (int i = 0; i < DEPTH - 1; i++) applyStimulus(DW'(200 + i));
        blk_ready = 1'b1;
        applyStimulus(DW'(999));
        blk_ready = 1'b0;
        pix_valid = 1'b0;
        checkOutput("ccOcc", 32'(occupancy), 1);
        checkOutput("ccValid", 32'(blk_valid), 1);
        checkOutput("ccBank", 32'(blk_bank), 1);
        checkOutput("ccCnt", 32'(blk_cnt), 1);
        checkOutput("ccReady", 32'(pix_ready), 1);
        checkOutput("ccLast", 32'(mem[1][63]), 999);

        // Gapped input, consumer always ready, 10 blocks.
        $display("[TB] gapped input");
        doReset();
        blk_ready = 1'b1;
        gapChk    = 1'b1;
        for (int k = 0; k < 10 * DEPTH; k++) begin
            if ($urandom_range(0, 1) == 0) begin
                pix_valid = 1'b0;
                tick();
            end
            applyStimulus(pixVal(k));
        end
        pix_valid = 1'b0;
        for (int n = 0; n < 20 && relCnt < 10; n++) tick();
        gapChk    = 1'b0;
        blk_ready = 1'b0;
        checkOutput("gapReleases", 32'(relCnt), 10);
        checkOutput("gapCnt", 32'(blk_cnt), 10);
        checkOutput("gapDataErr", 32'(gapDataErr), 0);
        checkOutput("gapBankErr", 32'(gapBankErr), 0);
        checkOutput("gapWrNoValid", 32'(wrViolations), 0);
        checkOutput("gapOcc", 32'(occupancy), 0);

        // Reset with bank0 FULL and 37 pixels in bank1.
        $display("[TB] reset mid-operation");
        doReset();
        for (int i = 0; i < DEPTH; i++) applyStimulus(DW'(i));
        for (int i = 0; i < 37; i++) applyStimulus(DW'(300 + i));
        pix_valid = 1'b0;
        checkOutput("midOccBefore", 32'(occupancy), 1);
        reset_n = 1'b0;
        #1;
        checkOutput("midReady", 32'(pix_ready), 1);
        checkOutput("midValid", 32'(blk_valid), 0);
        checkOutput("midBank", 32'(blk_bank), 0);
        checkOutput("midOcc", 32'(occupancy), 0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) applyStimulus(DW'(500 + i));
        pix_valid = 1'b0;
        checkOutput("midWr0", 32'(cnt0), 64);
        checkOutput("midWr1", 32'(cnt1), 0);
        checkOutput("midValidAfter", 32'(blk_valid), 1);
        checkOutput("midBankAfter", 32'(blk_bank), 0);
        checkOutput("midData0", 32'(mem[0][0]), 500);
        checkOutput("midData37", 32'(mem[0][37]), 537);
        checkOutput("midData63", 32'(mem[0][63]), 563);

        // Block counter wrap on the small instance.
        $display("[TB] counter wrap");
        doReset();
        w_blk_ready = 1'b1;
        w_pix_valid = 1'b1;
        for (int n = 0; n < 300 && w_blk_cnt != 4'hF; n++) tick();
        checkOutput("wrapPre", 32'(w_blk_cnt), 15);
        for (int n = 0; n < 20 && w_blk_cnt == 4'hF; n++) tick();
        checkOutput("wrapCnt", 32'(w_blk_cnt), 0);
        w_pix_valid = 1'b0;
        w_blk_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
